// File: rtl/opb_master_pkg.sv
// Shared types and constants for the OPB master bridge: FSM states,
// default OPB widths and the response error encoding.
package opb_master_pkg;

    localparam int OPB_AWIDTH    = 32;
    localparam int OPB_DWIDTH    = 32;
    localparam int MAX_RETRY_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        BACKOFF
    } state_e;

    typedef enum logic {
        RSP_OK  = 1'b0,
        RSP_ERR = 1'b1
    } rsp_err_e;

endpackage

// File: rtl/opb_retry_counter.sv
// Counts OPB retries for one command and flags when the next retry
// reaches the configured limit. Only built with OPB_MASTER_RETRY_LIMIT_EN.
module opb_retry_counter #(
    parameter int C_MAX_RETRY = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic incr_i,
    output logic last_o
);

    localparam int CW = $clog2(C_MAX_RETRY + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(C_MAX_RETRY - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (incr_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High while the count sits one below the limit: the retry seen now is the last allowed.
    assign last_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/opb_ppc_master_bridge.sv
// Single-beat OPB master driven by a valid/ready command port with a one-cycle
// response pulse. Define OPB_MASTER_RETRY_LIMIT_EN to bound OPB_retry attempts.
module opb_ppc_master_bridge
    import opb_master_pkg::*;
#(
    parameter int C_OPB_AWIDTH = OPB_AWIDTH,
    parameter int C_OPB_DWIDTH = OPB_DWIDTH,
    parameter int C_MAX_RETRY  = MAX_RETRY_DEF
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    output logic                      M_request,
    output logic                      M_select,
    output logic                      M_RNW,
    output logic [0:C_OPB_AWIDTH-1]   M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1] M_BE,
    output logic [0:C_OPB_DWIDTH-1]   M_DBus,
    output logic                      M_seqAddr,
    output logic                      M_busLock,
    input  logic                      OPB_MGrant,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_timeout,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
    input  logic [C_OPB_DWIDTH-1:0]   cmd_data,
    input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
    output logic                      rsp_valid,
    output logic [C_OPB_DWIDTH-1:0]   rsp_data,
    output logic                      rsp_err
);

    localparam int BEW = C_OPB_DWIDTH / 8;

    if (C_MAX_RETRY < 1) begin : g_cfg_check
        $error("C_MAX_RETRY must be at least 1");
    end

    state_e                    state_q, state_d;
    logic                      rnw_q, rnw_d;
    logic [C_OPB_AWIDTH-1:0]   addr_q, addr_d;
    logic [C_OPB_DWIDTH-1:0]   data_q, data_d;
    logic [BEW-1:0]            be_q, be_d;

    logic                      m_request_q, m_request_d;
    logic                      m_select_q, m_select_d;
    logic                      m_rnw_q, m_rnw_d;
    logic [0:C_OPB_AWIDTH-1]   m_abus_q, m_abus_d;
    logic [0:BEW-1]            m_be_q, m_be_d;
    logic [0:C_OPB_DWIDTH-1]   m_dbus_q, m_dbus_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [C_OPB_DWIDTH-1:0]   rsp_data_q, rsp_data_d;
    rsp_err_e                  rsp_err_q, rsp_err_d;

    logic                      drive_bus;
    logic                      fail_rsp;

`ifdef OPB_MASTER_RETRY_LIMIT_EN
    logic retry_clr, retry_inc, retry_last;

    opb_retry_counter #(
        .C_MAX_RETRY(C_MAX_RETRY)
    ) u_retry_counter (
        .clk_i  (OPB_Clk),
        .rst_i  (OPB_Rst),
        .clear_i(retry_clr),
        .incr_i (retry_inc),
        .last_o (retry_last)
    );
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves a latch.
        state_d     = state_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        m_request_d = 1'b0;
        m_select_d  = 1'b0;
        m_rnw_d     = 1'b0;
        m_abus_d    = '0;
        m_be_d      = '0;
        m_dbus_d    = '0;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        drive_bus   = 1'b0;
        fail_rsp    = 1'b0;
`ifdef OPB_MASTER_RETRY_LIMIT_EN
        retry_clr   = 1'b0;
        retry_inc   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    rnw_d       = cmd_rnw;
                    addr_d      = cmd_addr;
                    data_d      = cmd_data;
                    be_d        = cmd_be;
                    cmd_ready_d = 1'b0;
                    m_request_d = 1'b1;
                    state_d     = REQ;
`ifdef OPB_MASTER_RETRY_LIMIT_EN
                    retry_clr   = 1'b1;
`endif
                end
            end
            REQ: begin
                if (OPB_MGrant) begin
                    drive_bus = 1'b1;
                    state_d   = XFER;
                end else begin
                    m_request_d = 1'b1;
                end
            end
            XFER: begin
                // xferAck wins, except that xferAck with errAck is still an error.
                if (OPB_xferAck && !OPB_errAck) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = RSP_OK;
                    rsp_data_d  = rnw_q ? C_OPB_DWIDTH'(OPB_DBus) : '0;
                end else if (OPB_errAck || OPB_timeout) begin
                    fail_rsp = 1'b1;
                end else if (OPB_retry) begin
`ifdef OPB_MASTER_RETRY_LIMIT_EN
                    retry_inc = 1'b1;
                    if (retry_last) begin
                        fail_rsp = 1'b1;
                    end else begin
                        state_d = BACKOFF;
                    end
`else
                    state_d = BACKOFF;
`endif
                end else begin
                    drive_bus = 1'b1;
                end
            end
            BACKOFF: begin
                m_request_d = 1'b1;
                state_d     = REQ;
            end
            default: state_d = IDLE;
        endcase

        if (fail_rsp) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = RSP_ERR;
            rsp_data_d  = '0;
        end

        // OR-bus: address, control and data are nonzero only while selected.
        if (drive_bus) begin
            m_select_d = 1'b1;
            m_rnw_d    = rnw_q;
            m_abus_d   = addr_q;
            m_be_d     = be_q;
            m_dbus_d   = rnw_q ? '0 : data_q;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (OPB_Rst) begin
            state_q     <= IDLE;
            m_request_q <= 1'b0;
            m_select_q  <= 1'b0;
            m_rnw_q     <= 1'b0;
            m_abus_q    <= '0;
            m_be_q      <= '0;
            m_dbus_q    <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= RSP_OK;
        end else begin
            state_q     <= state_d;
            m_request_q <= m_request_d;
            m_select_q  <= m_select_d;
            m_rnw_q     <= m_rnw_d;
            m_abus_q    <= m_abus_d;
            m_be_q      <= m_be_d;
            m_dbus_q    <= m_dbus_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: the command latch needs no reset; it is always loaded before it is read.
    always_ff @(posedge OPB_Clk) begin
        rnw_q  <= rnw_d;
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
    end

    assign M_request = m_request_q;
    assign M_select  = m_select_q;
    assign M_RNW     = m_rnw_q;
    assign M_ABus    = m_abus_q;
    assign M_BE      = m_be_q;
    assign M_DBus    = m_dbus_q;
    assign M_seqAddr = 1'b0;
    assign M_busLock = 1'b0;
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/opb_ppc_master_bridge.md
Name: opb_ppc_master_bridge

Overview:
- OPB bus master: the initiator counterpart to the team's opb_register_* slave cores.
- Lets fabric logic issue single-beat OPB reads/writes into the PPC/OPB address space (slave registers, BRAM, status cores) through a simple valid/ready command port and a one-cycle response pulse.
- Sits alongside the OPB slave wrappers on the same OPB_Clk domain; arbitration goes through the existing OPB arbiter.

Parameters:
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_MAX_RETRY, 8, retry attempts before error (used only with OPB_MASTER_RETRY_LIMIT_EN).

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst  in  1  synchronous, active-high reset.
- M_request  out  1  bus request to arbiter.
- M_select  out  1  master owns bus, address/control valid.
- M_RNW  out  1  1=read, 0=write.
- M_ABus  out  [0:31]  address.
- M_BE  out  [0:3]  byte enables.
- M_DBus  out  [0:31]  write data.
- M_seqAddr  out  1  held 0 (no bursts).
- M_busLock  out  1  held 0.
- OPB_MGrant  in  1  grant from arbiter.
- OPB_xferAck  in  1  slave completion.
- OPB_errAck  in  1  slave error.
- OPB_retry  in  1  slave retry.
- OPB_timeout  in  1  arbiter timeout.
- OPB_DBus  in  [0:31]  read data.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts command.
- cmd_rnw  in  1  command direction.
- cmd_addr  in  [31:0]  byte address.
- cmd_data  in  [31:0]  write data.
- cmd_be  in  [3:0]  byte enables.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  [31:0]  read data; 0 on writes/errors.
- rsp_err  out  1  errAck, timeout or retry-limit.

Behaviour:
- Clock and reset: one clock (OPB_Clk); reset is synchronous, active-high (OPB_Rst). Reset values: every output 0 except cmd_ready=0 during reset and 1 the cycle after; state IDLE.
- Bit mapping: user [31:0] maps directly to OPB [0:31] (cmd_addr[31] -> M_ABus[0]); same for data and BE.
- OR-bus rule: M_ABus, M_BE, M_DBus, M_RNW are 0 whenever M_select=0.
- All outputs are registered.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready latches rnw/addr/data/be and goes to REQ.
- REQ: M_request=1. OPB_MGrant sampled high -> next cycle XFER with M_select=1, M_request=0, bus driven.
- XFER, checked in priority order:
  - OPB_xferAck: capture OPB_DBus if read; rsp_valid=1, rsp_err=0 next cycle; -> IDLE.
  - Else OPB_errAck or OPB_timeout: rsp_valid=1, rsp_err=1, rsp_data=0; -> IDLE.
  - Else OPB_retry: M_select=0 next cycle, one BACKOFF cycle, then REQ.
  - Else hold.
- BACKOFF: all bus outputs 0 for 1 cycle -> REQ.
- Simultaneous completion: xferAck+errAck in the same cycle is an error (rsp_err=1). xferAck+retry completes normally.
- Minimum latency: cmd accept c0 -> M_request c1; grant c1 -> M_select c2; xferAck c2 -> rsp_valid c3.
- Only one command outstanding; cmd_ready=0 from acceptance until the cycle after rsp_valid.
- rsp_data/rsp_err hold their values until the next rsp_valid.
- Reset mid-operation: the command is dropped with no rsp_valid, and bus outputs are 0 at the next edge.

Optional Feature:
- OPB_MASTER_RETRY_LIMIT_EN defined: a retry counter (width clog2(C_MAX_RETRY+1)) clears on command accept and increments per OPB_retry. On the retry that makes count==C_MAX_RETRY, the bridge goes to IDLE with rsp_valid=1, rsp_err=1 instead of BACKOFF.
- Undefined: retries repeat indefinitely; no counter logic.

Decomposition:
- Package opb_master_pkg:
  - state enum (IDLE, REQ, XFER, BACKOFF)
  - OPB width constants
  - rsp error encoding
- Sub-module opb_retry_counter (counter + limit compare), instantiated only under the macro.
- FSM and datapath stay in the top module.

Test Plan:
- Write 0xDEADBEEF to 0x01080500, BE=0xF, grant same cycle, xferAck 1 cycle after select -> M_ABus=0x01080500 while select; rsp_valid at c3, rsp_err=0.
- Read 0x01080504, slave returns 0x12345678 with xferAck after 3 wait cycles -> rsp_data=0x12345678; bus outputs 0 after select drops.
- Grant withheld 10 cycles -> M_request held high, M_select=0, cmd_ready=0 throughout.
- OPB_retry on first select -> select drops, 1 BACKOFF cycle, re-request, second attempt acked. With macro and C_MAX_RETRY=2, persistent retry -> rsp_err=1 after 2nd retry.
- OPB_timeout at 16 cycles, and xferAck+errAck in the same cycle -> rsp_err=1, rsp_data=0.
- OPB_Rst asserted in XFER -> next cycle all outputs 0, no rsp_valid; cmd_ready=1 the cycle after reset deasserts.
